// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers and counter mode encodings.
package gray_pkg;
  localparam int GRAY_MAX_W = 16;
  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended inputs decode correctly: the leading zeros leave the prefix XOR unchanged.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary decoder, WIDTH bits.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  logic [GRAY_MAX_W-1:0] g16, b16;

  assign g16 = GRAY_MAX_W'(gray);
  assign b16 = gray2bin(g16);
  assign bin = b16[WIDTH-1:0];
endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray-code counter with load, wrap/saturate ends, sticky end flags and Tc pulse.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int SATURATE = MODE_WRAP,
  parameter int INIT_BIN = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Gray,
  input  logic             Clr_Flags,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Output_Bin,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Tc
);
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_BIN);
  localparam bit               SAT  = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] cnt, cnt_nxt, load_bin;
  logic             tc_nxt, ovf_set, unf_set;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_dec (
    .gray (Load_Gray),
    .bin  (load_bin)
  );

  always_comb begin
    cnt_nxt = cnt;
    tc_nxt  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (Load) begin
      cnt_nxt = load_bin;
    end else if (En) begin
      if (Up) begin
        if (cnt == MAX) begin
          ovf_set = 1'b1;
          tc_nxt  = 1'b1;
          cnt_nxt = SAT ? MAX : '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        if (cnt == '0) begin
          unf_set = 1'b1;
          tc_nxt  = 1'b1;
          cnt_nxt = SAT ? '0 : MAX;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    end
  end

  // A flag set on the same edge as Clr_Flags wins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= INIT;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Tc        <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      Tc        <= tc_nxt;
      Overflow  <= ovf_set | (Overflow  & ~Clr_Flags);
      Underflow <= unf_set | (Underflow & ~Clr_Flags);
    end
  end

  assign Output     = cnt ^ (cnt >> 1);
  assign Output_Bin = cnt;
endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench: 3-bit wrap, 4-bit saturate (INIT_BIN=5) and 8-bit wrap instances.
module tb_gray_counter_n;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // instance A: WIDTH=3, wrap
  logic       a_rst, a_en, a_up, a_ld, a_clr;
  logic [2:0] a_lg, a_out, a_bin;
  logic       a_ovf, a_unf, a_tc;
  // instance B: WIDTH=4, saturate, INIT_BIN=5
  logic       b_rst, b_en, b_up, b_ld, b_clr;
  logic [3:0] b_lg, b_out, b_bin;
  logic       b_ovf, b_unf, b_tc;
  // instance C: WIDTH=8, wrap
  logic       c_rst, c_en, c_up, c_ld, c_clr;
  logic [7:0] c_lg, c_out, c_bin;
  logic       c_ovf, c_unf, c_tc;

  gray_counter_n #(.WIDTH(3), .SATURATE(0), .INIT_BIN(0)) dut_a (
    .Clk(Clk), .Reset(a_rst), .En(a_en), .Up(a_up), .Load(a_ld), .Load_Gray(a_lg),
    .Clr_Flags(a_clr), .Output(a_out), .Output_Bin(a_bin), .Overflow(a_ovf),
    .Underflow(a_unf), .Tc(a_tc));

  gray_counter_n #(.WIDTH(4), .SATURATE(1), .INIT_BIN(5)) dut_b (
    .Clk(Clk), .Reset(b_rst), .En(b_en), .Up(b_up), .Load(b_ld), .Load_Gray(b_lg),
    .Clr_Flags(b_clr), .Output(b_out), .Output_Bin(b_bin), .Overflow(b_ovf),
    .Underflow(b_unf), .Tc(b_tc));

  gray_counter_n #(.WIDTH(8), .SATURATE(0), .INIT_BIN(0)) dut_c (
    .Clk(Clk), .Reset(c_rst), .En(c_en), .Up(c_up), .Load(c_ld), .Load_Gray(c_lg),
    .Clr_Flags(c_clr), .Output(c_out), .Output_Bin(c_bin), .Overflow(c_ovf),
    .Underflow(c_unf), .Tc(c_tc));

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1; b_rst = 1; c_rst = 1;
    tick();
    total++;
    if (a_out !== 3'd0 || a_ovf !== 1'b0 || a_unf !== 1'b0 || a_tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_a: out=%b ovf=%b unf=%b tc=%b want out=000 flags=0 tc=0", a_out, a_ovf, a_unf, a_tc);
    end
    total++;
    if (b_bin !== 4'd5 || b_out !== 4'b0111 || b_ovf !== 1'b0 || b_unf !== 1'b0 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: bin=%0d out=%b ovf=%b unf=%b tc=%b want bin=5 out=0111 flags=0", b_bin, b_out, b_ovf, b_unf, b_tc);
    end
    a_rst = 0; b_rst = 0; c_rst = 0;
  endtask

  task automatic test_wrap_up;
    logic [2:0] exp_seq [8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
    a_rst = 1; tick(); a_rst = 0;
    a_en = 1; a_up = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (a_out !== exp_seq[i] || a_tc !== (i == 7) || a_ovf !== (i == 7)) begin
        bad++;
        $display("FAIL wrap_up step%0d: out=%b tc=%b ovf=%b want out=%b tc=%b ovf=%b",
                 i, a_out, a_tc, a_ovf, exp_seq[i], (i == 7), (i == 7));
      end
    end
    tick();
    total++;
    if (a_out !== 3'd1 || a_tc !== 1'b0 || a_ovf !== 1'b1) begin
      bad++;
      $display("FAIL wrap_up_after: out=%b tc=%b ovf=%b want out=001 tc=0 ovf=1", a_out, a_tc, a_ovf);
    end
    a_en = 0;
  endtask

  task automatic test_wrap_down;
    a_rst = 1; tick(); a_rst = 0;
    a_en = 1; a_up = 0;
    tick();
    total++;
    if (a_out !== 3'b100 || a_bin !== 3'd7 || a_unf !== 1'b1 || a_tc !== 1'b1 || a_ovf !== 1'b0) begin
      bad++;
      $display("FAIL wrap_down: out=%b bin=%0d unf=%b tc=%b ovf=%b want out=100 bin=7 unf=1 tc=1 ovf=0",
               a_out, a_bin, a_unf, a_tc, a_ovf);
    end
    a_up = 1;
    tick();
    total++;
    if (a_out !== 3'b000 || a_ovf !== 1'b1 || a_unf !== 1'b1 || a_tc !== 1'b1) begin
      bad++;
      $display("FAIL dir_change: out=%b ovf=%b unf=%b tc=%b want out=000 ovf=1 unf=1 tc=1", a_out, a_ovf, a_unf, a_tc);
    end
    a_en = 0;
  endtask

  task automatic test_saturate;
    b_ld = 1; b_lg = 4'b1000;
    tick();
    total++;
    if (b_bin !== 4'd15 || b_out !== 4'b1000 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL sat_load: bin=%0d out=%b tc=%b want bin=15 out=1000 tc=0", b_bin, b_out, b_tc);
    end
    b_ld = 0; b_en = 1; b_up = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (b_out !== 4'b1000 || b_tc !== 1'b1 || b_ovf !== 1'b1) begin
        bad++;
        $display("FAIL sat_hold_up%0d: out=%b tc=%b ovf=%b want out=1000 tc=1 ovf=1", i, b_out, b_tc, b_ovf);
      end
    end
    b_en = 0;
    tick();
    total++;
    if (b_tc !== 1'b0 || b_ovf !== 1'b1) begin
      bad++;
      $display("FAIL sat_idle: tc=%b ovf=%b want tc=0 ovf=1", b_tc, b_ovf);
    end
    b_ld = 1; b_lg = 4'b0000;
    tick();
    b_ld = 0; b_en = 1; b_up = 0;
    tick();
    total++;
    if (b_out !== 4'b0000 || b_tc !== 1'b1 || b_unf !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold_down: out=%b tc=%b unf=%b want out=0000 tc=1 unf=1", b_out, b_tc, b_unf);
    end
    b_en = 0;
  endtask

  task automatic test_priority;
    b_ld = 1; b_en = 1; b_up = 1; b_lg = 4'b0110;
    tick();
    total++;
    if (b_bin !== 4'd4 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL load_over_en: bin=%0d tc=%b want bin=4 tc=0", b_bin, b_tc);
    end
    b_rst = 1; b_lg = 4'b1000;
    tick();
    total++;
    if (b_bin !== 4'd5 || b_ovf !== 1'b0 || b_unf !== 1'b0 || b_tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_over_load: bin=%0d ovf=%b unf=%b tc=%b want bin=5 flags=0 tc=0", b_bin, b_ovf, b_unf, b_tc);
    end
    b_rst = 0; b_ld = 0; b_en = 0;
  endtask

  task automatic test_flags;
    a_rst = 1; tick(); a_rst = 0;
    a_ld = 1; a_lg = 3'b100;
    tick();
    a_ld = 0; a_en = 1; a_up = 1;
    tick();
    a_up = 0;
    tick();
    total++;
    if (a_bin !== 3'd7 || a_ovf !== 1'b1 || a_unf !== 1'b1) begin
      bad++;
      $display("FAIL flags_setup: bin=%0d ovf=%b unf=%b want bin=7 ovf=1 unf=1", a_bin, a_ovf, a_unf);
    end
    a_up = 1; a_clr = 1;
    tick();
    total++;
    if (a_bin !== 3'd0 || a_ovf !== 1'b1 || a_unf !== 1'b0 || a_tc !== 1'b1) begin
      bad++;
      $display("FAIL set_wins_clr: bin=%0d ovf=%b unf=%b tc=%b want bin=0 ovf=1 unf=0 tc=1", a_bin, a_ovf, a_unf, a_tc);
    end
    a_en = 0; a_clr = 0;
    tick();
    total++;
    if (a_ovf !== 1'b1 || a_tc !== 1'b0) begin
      bad++;
      $display("FAIL sticky: ovf=%b tc=%b want ovf=1 tc=0", a_ovf, a_tc);
    end
    a_clr = 1;
    tick();
    total++;
    if (a_ovf !== 1'b0 || a_unf !== 1'b0 || a_bin !== 3'd0) begin
      bad++;
      $display("FAIL clr_alone: ovf=%b unf=%b bin=%0d want ovf=0 unf=0 bin=0", a_ovf, a_unf, a_bin);
    end
    a_clr = 0;
  endtask

  task automatic test_random8;
    logic [7:0] m, prev, expg;
    logic       exp_tc;
    c_rst = 1; tick(); c_rst = 0;
    m = 8'd0;
    for (int i = 0; i < 300; i++) begin
      prev   = c_out;
      c_en   = ($urandom_range(0, 3) != 0);
      c_up   = ($urandom_range(0, 1) == 1);
      // bias toward the ends so wraps happen both ways
      if (i == 100) begin m = 8'd255; c_ld = 1; c_lg = 8'b1000_0000; c_en = 0; end
      else c_ld = 0;
      exp_tc = 1'b0;
      if (c_ld) m = 8'd255;
      else if (c_en && c_up)  begin exp_tc = (m == 8'd255); m = m + 8'd1; end
      else if (c_en && !c_up) begin exp_tc = (m == 8'd0);   m = m - 8'd1; end
      tick();
      expg = m ^ (m >> 1);
      total++;
      if (c_bin !== m || c_out !== expg || c_tc !== exp_tc) begin
        bad++;
        $display("FAIL rand8 cyc%0d: bin=%0d out=%b tc=%b want bin=%0d out=%b tc=%b", i, c_bin, c_out, c_tc, m, expg, exp_tc);
      end
      if (!c_ld) begin
        total++;
        if ($countones(c_out ^ prev) != (c_en ? 1 : 0)) begin
          bad++;
          $display("FAIL rand8_onebit cyc%0d: changed=%0d want %0d", i, $countones(c_out ^ prev), (c_en ? 1 : 0));
        end
      end
    end
    c_en = 0; c_ld = 0;
  endtask

  initial begin
    a_rst = 0; a_en = 0; a_up = 0; a_ld = 0; a_clr = 0; a_lg = '0;
    b_rst = 0; b_en = 0; b_up = 0; b_ld = 0; b_clr = 0; b_lg = '0;
    c_rst = 0; c_en = 0; c_up = 0; c_ld = 0; c_clr = 0; c_lg = '0;
    #1;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_flags();
    test_random8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
